// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   strb_w()    : byte-strobe width for a given data width
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_BUSY = 2'b01,
    D_BUSY  = 2'b10,
    RESP    = 2'b11
  } arb_state_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard: counts consecutive data grants made while a fetch
// is waiting, and forces the next grant to fetch once the limit is reached.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   if_req     : fetch request pending
//   d_req      : data request pending
//   arb_en     : arbiter is in IDLE this cycle (a grant happens at the edge
//                if any request is pending)
//   sel_fetch  : 1 = fetch wins the current arbitration, 0 = data wins
module mem_arb_starve_ctr #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic arb_en,
  output logic sel_fetch
);

  localparam int CNT_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_STREAK);

  logic [CNT_W-1:0] streak_reg, streak_next;
  logic             grant;

  assign grant     = arb_en && (if_req || d_req);
  // Data wins unless fetch is alone or has waited out a full streak.
  assign sel_fetch = if_req && (!d_req || (streak_reg == CNT_MAX));

  always_comb begin
    streak_next = streak_reg;
    if (arb_en && !if_req) begin
      // No fetch waiting: nothing to count against.
      streak_next = '0;
    end else if (grant) begin
      if (sel_fetch) begin
        streak_next = '0;
      end else if (streak_reg != CNT_MAX) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store path.
// Data has priority; a streak counter guarantees fetch forward progress.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   if_req/if_addr                 : fetch request, held until if_ack
//   if_rdata/if_ack                : fetch data + one-cycle completion
//   d_req/d_we/d_addr/d_wdata/d_wstrb : load/store request, held until d_ack
//   d_rdata/d_ack                  : load data + one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : memory request, held to mem_ack
//   mem_rdata/mem_ack              : memory response (ack is a 1-cycle pulse)
//   busy                           : arbiter not in IDLE
//   err                            : sticky, mem_ack seen with no access open
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDR_W-1:0]         if_addr,
  output logic [DATA_W-1:0]         if_rdata,
  output logic                      if_ack,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [DATA_W-1:0]         d_wdata,
  input  logic [strb_w(DATA_W)-1:0] d_wstrb,
  output logic [DATA_W-1:0]         d_rdata,
  output logic                      d_ack,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [strb_w(DATA_W)-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic                      err
);

  localparam int STRB_W = strb_w(DATA_W);

  arb_state_t        state_reg, state_next;
  logic              sel_fetch;
  logic              arb_en;
  logic              grant;
  logic              win_d_reg;   // owner of the open access, needed in RESP
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [STRB_W-1:0] mem_wstrb_reg, wstrb_next;
  logic [DATA_W-1:0] if_rdata_reg, d_rdata_reg;
  logic              err_reg;

  assign arb_en = (state_reg == IDLE);
  assign grant  = arb_en && (if_req || d_req);

  mem_arb_starve_ctr #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .d_req    (d_req),
    .arb_en   (arb_en),
    .sel_fetch(sel_fetch)
  );

  // A fetch never writes, so its strobes are forced low.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign wstrb_next[gi] = d_wstrb[gi] & ~sel_fetch;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = sel_fetch ? IF_BUSY : D_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ack) begin
          state_next = RESP;
        end
      end
      // RESP always returns to IDLE, so a requester still holding req in
      // its ack cycle cannot be granted a second time.
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      win_d_reg     <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        win_d_reg     <= ~sel_fetch;
        mem_addr_reg  <= sel_fetch ? if_addr : d_addr;
        mem_we_reg    <= ~sel_fetch & d_we;
        mem_wdata_reg <= sel_fetch ? '0 : d_wdata;
        mem_wstrb_reg <= wstrb_next;
      end
      if (mem_ack && (state_reg == IF_BUSY)) begin
        if_rdata_reg <= mem_rdata;
      end
      if (mem_ack && (state_reg == D_BUSY)) begin
        d_rdata_reg <= mem_rdata;
      end
      // An ack with no access open is a protocol error; it is only flagged.
      if (mem_ack && ((state_reg == IDLE) || (state_reg == RESP))) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign mem_req   = (state_reg == IF_BUSY) || (state_reg == D_BUSY);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign if_ack    = (state_reg == RESP) && !win_d_reg;
  assign d_ack     = (state_reg == RESP) && win_d_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tracks the open access in terms of clock-edge numbers.
  int            edge_n;
  bit            m_txn;         // an access is open (memory request expected)
  bit            m_resp;        // this cycle is the completion cycle
  bit            m_win_d;       // open/last access belongs to the data port
  int            m_grant_edge, m_ack_edge, m_free_edge;
  int            m_streak;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  logic [SW-1:0] e_wstrb;
  logic [DW-1:0] e_if_rdata, e_d_rdata;
  bit            e_err;

  // Stimulus control
  int            cfg_wait;      // memory wait states, -1 = random 0..3
  bit            fixed_en;
  logic [DW-1:0] fixed_val;
  int            rmode;         // 0 drop after ack, 1 renew, 2 random
  bit            if_done, d_done;
  bit            prev_mem_req;
  int            cnt_mem_req, cnt_if_ack, cnt_d_ack;
  logic [AW-1:0] glog[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic model_reset();
    m_txn = 0; m_resp = 0; m_win_d = 0;
    m_grant_edge = 0; m_ack_edge = 0; m_free_edge = 0; m_streak = 0;
    e_addr = '0; e_we = 0; e_wdata = '0; e_wstrb = '0;
    e_if_rdata = '0; e_d_rdata = '0; e_err = 0;
    prev_mem_req = 0; if_done = 0; d_done = 0;
  endtask

  // Advance the model over the edge just taken (inputs are still the values
  // that edge sampled), then compare every output against it.
  task automatic model_step();
    bit was_txn;
    bit win_d;
    bit do_grant;
    was_txn  = m_txn;
    m_resp   = 0;
    do_grant = 0;
    win_d    = 0;
    if (mem_ack) begin
      if (was_txn) begin
        m_txn       = 0;
        m_resp      = 1;
        m_free_edge = edge_n + 2;
        if (m_win_d) e_d_rdata = mem_rdata;
        else         e_if_rdata = mem_rdata;
      end else begin
        e_err = 1;
      end
    end
    if (!was_txn && edge_n >= m_free_edge) begin
      if (if_req && (!d_req || m_streak == MAXS)) begin
        do_grant = 1; win_d = 0; m_streak = 0;
      end else if (d_req) begin
        do_grant = 1; win_d = 1;
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else begin
        m_streak = 0;
      end
    end
    if (do_grant) begin
      m_txn        = 1;
      m_win_d      = win_d;
      m_grant_edge = edge_n;
      m_ack_edge   = edge_n + 1 + ((cfg_wait >= 0) ? cfg_wait : int'($urandom_range(0, 3)));
      e_addr       = win_d ? d_addr : if_addr;
      e_we         = win_d ? d_we : 1'b0;
      e_wdata      = d_wdata;
      e_wstrb      = win_d ? d_wstrb : '0;
    end
    chk("mem_req", mem_req, m_txn);
    chk("busy", busy, m_txn || m_resp);
    chk("if_ack", if_ack, m_resp && !m_win_d);
    chk("d_ack", d_ack, m_resp && m_win_d);
    if (m_txn) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_wstrb", mem_wstrb, e_wstrb);
      if (m_win_d) chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("err", err, e_err);
  endtask

  task automatic new_if();
    if_req  = 1;
    if_addr = $urandom & 32'hFFFF_7FFC;
  endtask

  task automatic new_d();
    d_req   = 1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = ($urandom & 32'hFFFF_FFFC) | 32'h0000_8000;
    d_wdata = $urandom;
    d_wstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_mem();
    mem_ack   = m_txn && (edge_n + 1 == m_ack_edge);
    mem_rdata = fixed_en ? fixed_val : $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    model_step();
    if (mem_req) cnt_mem_req++;
    if (if_ack)  cnt_if_ack++;
    if (d_ack)   cnt_d_ack++;
    if (mem_req && !prev_mem_req) glog.push_back(mem_addr);
    prev_mem_req = mem_req;
    // Requesters hold req through their ack cycle and move on one cycle later.
    if (if_done) begin
      if_done = 0;
      if (rmode == 1 || (rmode == 2 && $urandom_range(0, 1) == 1)) new_if();
      else if_req = 0;
    end
    if (d_done) begin
      d_done = 0;
      if (rmode == 1 || (rmode == 2 && $urandom_range(0, 1) == 1)) new_d();
      else d_req = 0;
    end
    if (m_resp && !m_win_d) if_done = 1;
    if (m_resp && m_win_d)  d_done = 1;
    if (rmode == 2) begin
      if (!if_req && $urandom_range(0, 3) == 0) new_if();
      if (!d_req && $urandom_range(0, 3) == 0) new_d();
    end
    drive_mem();
  endtask

  task automatic wait_ack(input bit want_d, input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_resp && (m_win_d == want_d)) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_ack_timeout"}, got, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!if_req && !d_req && !m_txn && !m_resp) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_idle_timeout"}, ok, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    if_req = 0; d_req = 0; mem_ack = 0;
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    edge_n += 2;
    rst = 0;
    model_reset();
  endtask

  int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst = 1;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_rdata = '0; mem_ack = 0;
    edge_n = 0; cfg_wait = 0; fixed_en = 0; fixed_val = '0; rmode = 0;
    cnt_mem_req = 0; cnt_if_ack = 0; cnt_d_ack = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    do_reset();
    tick();

    // 1: reset in the middle of a fetch aborts it with no ack
    if_req = 1; if_addr = 32'h100; cfg_wait = 6;
    tick();
    chk("t1_mem_req_granted", mem_req, 1);
    rst = 1; mem_ack = 0;
    #1;
    chk_all_zero("t1_async");
    @(posedge clk);
    #1;
    edge_n++;
    chk_all_zero("t1_held");
    rst = 0;
    model_reset();
    if_addr = 32'h104; cfg_wait = 0;
    cnt_if_ack = 0;
    wait_ack(0, "t1_refetch");
    chk("t1_mem_addr_after", if_addr, 32'h104);
    wait_idle("t1");
    chk("t1_if_ack_count", cnt_if_ack, 1);

    // 2: single fetch, zero-wait memory
    cnt_if_ack = 0; cnt_d_ack = 0;
    fixed_en = 1; fixed_val = 32'h13; mem_rdata = fixed_val;
    if_req = 1; if_addr = 32'h40;
    tick();
    chk("t2_mem_req_n1", mem_req, 1);
    chk("t2_mem_we_n1", mem_we, 0);
    chk("t2_mem_addr_n1", mem_addr, 32'h40);
    tick();
    chk("t2_if_ack_n2", if_ack, 1);
    chk("t2_if_rdata_n2", if_rdata, 32'h13);
    wait_idle("t2");
    chk("t2_d_ack_count", cnt_d_ack, 0);
    chk("t2_if_ack_count", cnt_if_ack, 1);

    // 3: store with two wait states
    cnt_mem_req = 0; cnt_d_ack = 0; cnt_if_ack = 0;
    fixed_val = 32'h5555_AAAA; cfg_wait = 2;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    tick();
    chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t3_mem_wstrb", mem_wstrb, 4'b0011);
    chk("t3_mem_we", mem_we, 1);
    wait_ack(1, "t3");
    wait_idle("t3");
    chk("t3_mem_req_cycles", cnt_mem_req, 3);
    chk("t3_d_ack_count", cnt_d_ack, 1);
    chk("t3_if_ack_count", cnt_if_ack, 0);

    // 4: both requesters continuously pending
    cfg_wait = 0; fixed_en = 0; rmode = 1;
    glog.delete();
    new_if();
    new_d();
    for (int i = 0; i < 150 && glog.size() < 10; i++) tick();
    chk("t4_grant_count", glog.size() >= 10, 1);
    for (int i = 0; i < 10 && i < glog.size(); i++) begin
      chk($sformatf("t4_grant_%0d_is_data", i), glog[i][15], exp_order[i]);
    end
    rmode = 0;
    wait_idle("t4");

    // 5: unexpected mem_ack in IDLE
    cnt_if_ack = 0; cnt_d_ack = 0;
    mem_ack = 1;
    tick();
    chk("t5_err_set", err, 1);
    tick();
    tick();
    chk("t5_err_sticky", err, 1);
    chk("t5_no_acks", cnt_if_ack + cnt_d_ack, 0);
    fixed_en = 1; fixed_val = 32'h0BAD_F00D;
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    wait_ack(1, "t5");
    chk("t5_d_rdata", d_rdata, 32'h0BAD_F00D);
    wait_idle("t5");
    chk("t5_err_still", err, 1);
    chk("t5_d_ack_count", cnt_d_ack, 1);

    // 6: load raised during the fetch's ack cycle
    fixed_val = 32'h1111_2222; mem_rdata = fixed_val;
    if_req = 1; if_addr = 32'h500;
    wait_ack(0, "t6_fetch");
    d_req = 1; d_we = 0; d_addr = 32'h6000;
    fixed_val = 32'hCAFE_0001;
    tick();
    chk("t6_no_grant_in_resp", mem_req, 0);
    tick();
    chk("t6_grant_next_idle", mem_req, 1);
    chk("t6_mem_addr", mem_addr, 32'h6000);
    wait_ack(1, "t6_load");
    chk("t6_d_rdata", d_rdata, 32'hCAFE_0001);
    chk("t6_if_rdata_kept", if_rdata, 32'h1111_2222);
    wait_idle("t6");

    // Randomized traffic with random wait states
    do_reset();
    cfg_wait = -1; fixed_en = 0; rmode = 2;
    repeat (1500) tick();
    rmode = 0;
    wait_idle("rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
